// File: rtl/text_pkg.sv
// Shared text-plane constants and clear-engine state encoding, used by the
// RAM arbiter, the video character fetch and the terminal parser.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int COL_W  = $clog2(COLS);

  localparam logic [DATA_W-1:0] CLR_WORD  = 16'h0720;
  localparam logic [4:0]        ROW_LIMIT = 5'(ROWS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } clr_state_t;

  // First word of a text row, kept in RAM address width so it wraps like the RAM does.
  function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
    return ADDR_W'(row) * ADDR_W'(COLS);
  endfunction

endpackage

// File: rtl/text_row_clear.sv
// Row-clear engine: walks one text row column by column, asking the arbiter
// for the RAM each cycle and advancing only when granted.
module text_row_clear
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        row,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output clr_state_t        state
);

  clr_state_t        state_next;
  logic [ADDR_W-1:0] base, base_next;
  logic [COL_W-1:0]  col, col_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      col   <= '0;
    end else begin
      state <= state_next;
      base  <= base_next;
      col   <= col_next;
    end
  end

  always_comb begin
    state_next = state;
    base_next  = base;
    col_next   = col;
    case (state)
      IDLE: begin
        // Out-of-range rows are dropped here so they never raise busy.
        if (start && (row < ROW_LIMIT)) begin
          state_next = RUN;
          base_next  = row_base(row);
          col_next   = '0;
        end
      end
      RUN: begin
        if (grant) begin
          col_next = col + 1'b1;
          if (col == LAST_COL) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req  = (state == RUN);
  assign addr = base + ADDR_W'(col);

endmodule

// File: rtl/text_ram_arbiter.sv
// Single-port text RAM arbiter: video fetch > terminal parser > row clear.
// Optional stall counters are built when TEXT_ARB_PERF_EN is defined.
module text_ram_arbiter
  import text_pkg::*;
(
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              term_valid,
  output logic              term_ready,
  input  logic              term_we,
  input  logic [ADDR_W-1:0] term_addr,
  input  logic [DATA_W-1:0] term_wdata,
  output logic              term_rvalid,
  output logic [DATA_W-1:0] term_rdata,
  input  logic              clr_start,
  input  logic [4:0]        clr_row,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef TEXT_ARB_PERF_EN
  ,
  output logic [15:0]       term_stall_cnt,
  output logic [15:0]       clr_stall_cnt
`endif
);

  // Terminal handshake: a transfer happens in a cycle where term_valid and
  // term_ready are both 1; the parser holds its request unchanged until then.
  // Reads answer with term_rvalid exactly one cycle later, writes never answer.
  logic              term_fire;
  logic              clr_req;
  logic              clr_grant;
  logic [ADDR_W-1:0] clr_addr;
  clr_state_t        clr_state;

  assign clr_busy   = (clr_state != IDLE);
  assign clr_done   = (clr_state == DONE);
  assign term_ready = !rst && !vid_req && !clr_busy;
  assign term_fire  = term_valid && term_ready;
  // A busy clear already blocks the terminal, so only video can take its slot.
  assign clr_grant  = clr_req && !vid_req && !rst;

  text_row_clear u_clear (
    .clk   (clk_25mhz),
    .rst   (rst),
    .start (clr_start),
    .row   (clr_row),
    .grant (clr_grant),
    .req   (clr_req),
    .addr  (clr_addr),
    .state (clr_state)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (vid_req) begin
        ram_en   = 1'b1;
        ram_addr = vid_addr;
      end else if (term_fire) begin
        ram_en    = 1'b1;
        ram_we    = term_we;
        ram_addr  = term_addr;
        ram_wdata = term_wdata;
      end else if (clr_req) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = CLR_WORD;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      vid_valid   <= 1'b0;
      term_rvalid <= 1'b0;
    end else begin
      vid_valid   <= vid_req;
      term_rvalid <= term_fire && !term_we;
    end
  end

  assign vid_data   = ram_rdata;
  assign term_rdata = ram_rdata;

`ifdef TEXT_ARB_PERF_EN
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      term_stall_cnt <= '0;
      clr_stall_cnt  <= '0;
    end else begin
      if (term_valid && !term_ready && (term_stall_cnt != 16'hFFFF))
        term_stall_cnt <= term_stall_cnt + 16'd1;
      if (clr_req && vid_req && (clr_stall_cnt != 16'hFFFF))
        clr_stall_cnt <= clr_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: directed scenarios then random traffic, all
// checked against a transaction-level model of the shared text RAM.
module tb_text_ram_arbiter;
  import text_pkg::*;

  logic              clk_25mhz = 1'b0;
  logic              rst;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              term_valid;
  logic              term_ready;
  logic              term_we;
  logic [ADDR_W-1:0] term_addr;
  logic [DATA_W-1:0] term_wdata;
  logic              term_rvalid;
  logic [DATA_W-1:0] term_rdata;
  logic              clr_start;
  logic [4:0]        clr_row;
  logic              clr_busy;
  logic              clr_done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef TEXT_ARB_PERF_EN
  logic [15:0]       term_stall_cnt;
  logic [15:0]       clr_stall_cnt;
`endif

  // clock / reset block
  always #20 clk_25mhz = ~clk_25mhz;

  text_ram_arbiter dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_valid   (vid_valid),
    .vid_data    (vid_data),
    .term_valid  (term_valid),
    .term_ready  (term_ready),
    .term_we     (term_we),
    .term_addr   (term_addr),
    .term_wdata  (term_wdata),
    .term_rvalid (term_rvalid),
    .term_rdata  (term_rdata),
    .clr_start   (clr_start),
    .clr_row     (clr_row),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
`ifdef TEXT_ARB_PERF_EN
    ,
    .term_stall_cnt (term_stall_cnt),
    .clr_stall_cnt  (clr_stall_cnt)
`endif
  );

  // single-port RAM with one-cycle read latency
  logic [DATA_W-1:0] mem [4096];
  bit                mem_init = 1'b0;

  always @(posedge clk_25mhz) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'(i * 7 + 3);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // reference model: RAM image, pending clear words, pending done pulse
  logic [DATA_W-1:0] ref_mem [4096];
  int                clr_q[$];
  bit                done_pending;
  int                m_term_stall;
  int                m_clr_stall;
  int                last_clr_wr;

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle with the given inputs, checked against the model
  task automatic step(input bit v, input logic [ADDR_W-1:0] va,
                      input bit tv, input bit twe, input logic [ADDR_W-1:0] ta,
                      input logic [DATA_W-1:0] twd,
                      input bit cs, input logic [4:0] cr);
    bit                busy_m, rdy, n_vv, n_tv, old_dp;
    int                kind;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] n_vd, n_td;
    vid_req = v; vid_addr = va;
    term_valid = tv; term_we = twe; term_addr = ta; term_wdata = twd;
    clr_start = cs; clr_row = cr;
    #1;
    busy_m = (clr_q.size() > 0) || done_pending;
    rdy    = !v && !busy_m;
    chk("term_ready", 32'(term_ready), 32'(rdy));
    chk("clr_busy",   32'(clr_busy),   32'(busy_m));
    chk("clr_done",   32'(clr_done),   32'(done_pending));
    kind = 0; e_addr = '0;
    if (v)                      begin kind = 1; e_addr = va; end
    else if (tv && rdy)         begin kind = 2; e_addr = ta; end
    else if (clr_q.size() > 0)  begin kind = 3; e_addr = 12'(clr_q[0]); end
    chk("ram_en", 32'(ram_en), 32'(kind != 0));
    if (kind != 0) begin
      chk("ram_we",   32'(ram_we),   32'(kind == 3 || (kind == 2 && twe)));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (kind == 3) chk("ram_wdata_clr", 32'(ram_wdata), 32'(CLR_WORD));
      if (kind == 2 && twe) chk("ram_wdata_term", 32'(ram_wdata), 32'(twd));
    end
    if (ram_en && ram_we && ram_wdata == CLR_WORD && busy_m) last_clr_wr = int'(ram_addr);
    if (tv && !rdy && m_term_stall < 65535) m_term_stall++;
    if (clr_q.size() > 0 && v && m_clr_stall < 65535) m_clr_stall++;
    n_vv = v;
    n_vd = ref_mem[va];
    n_tv = (kind == 2) && !twe;
    n_td = ref_mem[ta];
    if (kind == 2 && twe) ref_mem[ta] = twd;
    old_dp = done_pending;
    if (old_dp) done_pending = 1'b0;
    if (kind == 3) begin
      ref_mem[e_addr] = CLR_WORD;
      void'(clr_q.pop_front());
      if (clr_q.size() == 0) done_pending = 1'b1;
    end
    if (!busy_m && cs && int'(cr) < ROWS)
      for (int i = 0; i < COLS; i++) clr_q.push_back(int'(cr) * COLS + i);
    @(posedge clk_25mhz);
    #1;
    chk("vid_valid",   32'(vid_valid),   32'(n_vv));
    chk("term_rvalid", 32'(term_rvalid), 32'(n_tv));
    if (n_vv) chk("vid_data",   32'(vid_data),   32'(n_vd));
    if (n_tv) chk("term_rdata", 32'(term_rdata), 32'(n_td));
    @(negedge clk_25mhz);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    vid_req = 1'b0; vid_addr = '0;
    term_valid = 1'b0; term_we = 1'b0; term_addr = '0; term_wdata = '0;
    clr_start = 1'b0; clr_row = '0;
    #1;
    chk("rst_ram_en",     32'(ram_en),     32'd0);
    chk("rst_term_ready", 32'(term_ready), 32'd0);
    @(posedge clk_25mhz);
    #1;
    clr_q.delete();
    done_pending = 1'b0;
    m_term_stall = 0;
    m_clr_stall  = 0;
    chk("rst_vid_valid",   32'(vid_valid),   32'd0);
    chk("rst_term_rvalid", 32'(term_rvalid), 32'd0);
    chk("rst_clr_busy",    32'(clr_busy),    32'd0);
    chk("rst_clr_done",    32'(clr_done),    32'd0);
    @(negedge clk_25mhz);
    rst = 1'b0;
  endtask

  // run idle cycles (optionally holding a terminal read) until clr_done; returns cycles
  task automatic wait_done(input bit hold_term, output int n);
    n = 0;
    while (!clr_done && n < 200) begin
      step(1'b0, '0, hold_term, 1'b0, 12'd7, '0, 1'b0, '0);
      n++;
    end
    chk("clr_done_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'(i * 7 + 3);
    done_pending = 1'b0; last_clr_wr = -1;
    m_term_stall = 0; m_clr_stall = 0;
    rst = 1'b1; mem_init = 1'b1;
    vid_req = 1'b0; vid_addr = '0; term_valid = 1'b0; term_we = 1'b0;
    term_addr = '0; term_wdata = '0; clr_start = 1'b0; clr_row = '0;
    @(posedge clk_25mhz);
    #1 mem_init = 1'b0;
    @(negedge clk_25mhz);

    // reset then idle
    rst_cycle();
    rst_cycle();
    idle();

    // terminal write then read
    step(1'b0, '0, 1'b1, 1'b1, 12'd5, 16'h0741, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 12'd5, '0, 1'b0, '0);
    chk("rd5_data", 32'(term_rdata), 32'h0741);

    // video beats terminal, terminal follows in the first free cycle
    step(1'b1, 12'd10, 1'b1, 1'b0, 12'd20, '0, 1'b0, '0);
    step(1'b0, '0,     1'b1, 1'b0, 12'd20, '0, 1'b0, '0);

    // row 2 clear, terminal held waiting throughout
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd2);
    wait_done(1'b1, n);
    chk("row2_done_cycle", 32'(n + 1), 32'd81);
    chk("row2_last_addr",  32'(last_clr_wr), 32'd239);
    idle();

    // clear stalled by three video cycles
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd3);
    for (int i = 0; i < 20; i++) idle();
    for (int i = 0; i < 3; i++) step(1'b1, 12'(100 + i), 1'b0, 1'b0, '0, '0, 1'b0, '0);
    wait_done(1'b0, n);
    chk("row3_done_cycle", 32'(n + 24), 32'd84);
    idle();

    // out-of-range row is ignored
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd30);
    chk("row30_busy", 32'(clr_busy), 32'd0);
    idle();

    // last row ends at the last text cell
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd29);
    wait_done(1'b0, n);
    chk("row29_last_addr", 32'(last_clr_wr), 32'd2399);
    idle();

    // reset mid-clear aborts without a done pulse
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd4);
    for (int i = 0; i < 10; i++) idle();
    rst_cycle();
    for (int i = 0; i < 100; i++) idle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, 12'($urandom_range(0, 2399)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           12'($urandom_range(0, 2399)), 16'($urandom),
           $urandom_range(0, 19) == 0, 5'($urandom_range(0, 31)));
    end

`ifdef TEXT_ARB_PERF_EN
    chk("term_stall_cnt", 32'(term_stall_cnt), 32'(m_term_stall));
    chk("clr_stall_cnt",  32'(clr_stall_cnt),  32'(m_clr_stall));
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
